// File: rtl/spi_apb_regif.sv
// APB3 register front-end for an SPI core with TX/RX word FIFOs; one APB wait state per transfer.
// TX drains on tx_valid/tx_ready; RX pushes on rx_valid and drops into sticky ovr when full.

module sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_dat,
  input  logic              pop,
  output logic [DATA_W-1:0] head_dat,
  output logic [CNT_W-1:0]  count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge PCLK) begin
    if (push && !flush) mem[wr_ptr] <= push_dat;
  end

  // Caller only pushes with room (or a same-cycle pop) and only pops when not empty.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  assign head_dat = mem[rd_ptr];
endmodule

module spi_apb_regif #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [7:0]        SPICR_1,
  output logic [7:0]        SPICR_2,
  output logic [DATA_W-1:0] MWDATA,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] MRDATA,
  input  logic              rx_valid,
  input  logic [7:0]        SPISR,
  output logic              irq
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state, state_nxt;

  logic [7:0]        cr1;
  logic              cr2;
  logic              ovr;
  logic [4:0]        off;
  logic              err_cond, commit;
  logic [DATA_W-1:0] rd_dat;
  logic [DATA_W-1:0] tx_head, rx_head;
  logic [CNT_W-1:0]  tx_count, rx_count;
  logic              tx_full, rx_full, rx_empty;
  logic              tx_push, tx_pop, rx_push, rx_pop;
  logic              cr1_wr, flush, clr_wr, ovr_set;
  logic              unused_ok;

  assign off       = PADDR[4:0];
  assign unused_ok = ^PADDR[ADDR_W-1:5];

  // SETUP is entered after the bus setup cycle, so it spans the bus wait cycle.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (PSEL && !PENABLE) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (PREADY) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign PREADY   = (state == ACCESS);
  assign tx_full  = (tx_count == CNT_W'(FIFO_DEPTH));
  assign rx_full  = (rx_count == CNT_W'(FIFO_DEPTH));
  assign rx_empty = (rx_count == '0);

  always_comb begin
    err_cond = 1'b0;
    if (off[1:0] != 2'b00 || off > 5'h14) begin
      err_cond = 1'b1;
    end else if (PWRITE) begin
      case (off)
        5'h0C, 5'h10: err_cond = 1'b1;
        5'h08:        err_cond = tx_full;
        default:      err_cond = 1'b0;
      endcase
    end else begin
      case (off)
        5'h08, 5'h14: err_cond = 1'b1;
        5'h0C:        err_cond = rx_empty;
        default:      err_cond = 1'b0;
      endcase
    end
  end

  always_comb begin
    rd_dat = '0;
    case (off)
      5'h00: rd_dat[7:0] = cr1;
      5'h04: rd_dat[0]   = cr2;
      5'h0C: rd_dat      = rx_head;
      5'h10: begin
        rd_dat[15:8] = SPISR;
        rd_dat[6]    = ovr;
        rd_dat[5:3]  = 3'(rx_count);
        rd_dat[2:0]  = 3'(tx_count);
      end
      default: rd_dat = '0;
    endcase
  end

  assign PSLVERR = PREADY && err_cond;
  assign commit  = PREADY && !err_cond;
  assign PRDATA  = (commit && !PWRITE) ? rd_dat : '0;

  assign cr1_wr  = commit && PWRITE && (off == 5'h00);
  assign flush   = cr1_wr && cr1[6] && !PWDATA[6];
  assign clr_wr  = commit && PWRITE && (off == 5'h14) && PWDATA[0];
  assign tx_push = commit && PWRITE && (off == 5'h08);
  assign tx_pop  = tx_valid && tx_ready;
  assign rx_pop  = commit && !PWRITE && (off == 5'h0C);
  assign rx_push = rx_valid && (!rx_full || rx_pop);
  assign ovr_set = rx_valid && rx_full && !rx_pop;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cr1 <= 8'h00;
      cr2 <= 1'b0;
      ovr <= 1'b0;
      irq <= 1'b0;
    end else begin
      if (cr1_wr) cr1 <= PWDATA[7:0];
      if (commit && PWRITE && off == 5'h04) cr2 <= PWDATA[0];
      if (ovr_set)     ovr <= 1'b1;
      else if (clr_wr) ovr <= 1'b0;
      irq <= cr1[5] && (tx_count == '0 || rx_count != '0 || ovr);
    end
  end

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_tx_fifo (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .flush    (flush),
    .push     (tx_push),
    .push_dat (PWDATA),
    .pop      (tx_pop),
    .head_dat (tx_head),
    .count    (tx_count)
  );

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_rx_fifo (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .flush    (flush),
    .push     (rx_push),
    .push_dat (MRDATA),
    .pop      (rx_pop),
    .head_dat (rx_head),
    .count    (rx_count)
  );

  assign SPICR_1  = cr1;
  assign SPICR_2  = {7'b0, cr2};
  assign tx_valid = (tx_count != '0);
  assign MWDATA   = tx_valid ? tx_head : '0;
endmodule

// File: tb/tb_spi_apb_regif.sv
// Bench for spi_apb_regif: queue-based reference model checked every cycle, plus directed literal checks.
module tb_spi_apb_regif;
  localparam int DEPTH = 4;

  logic        PCLK, PRESETn;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PREADY, PSLVERR;
  logic [7:0]  SPICR_1, SPICR_2, SPISR;
  logic [31:0] MWDATA, MRDATA;
  logic        tx_valid, tx_ready, rx_valid, irq;

  int n_vec  = 0;
  int n_fail = 0;
  int phase  = 0;       // 0 idle, 1 setup, 2 first access cycle, 3 second access cycle
  bit rand_side = 0;

  logic [31:0] txq[$];
  logic [31:0] rxq[$];
  logic [7:0]  m_cr1;
  logic        m_cr2, m_ovr, m_irq;

  spi_apb_regif #(.ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(DEPTH)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .SPICR_1(SPICR_1), .SPICR_2(SPICR_2), .MWDATA(MWDATA), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .MRDATA(MRDATA), .rx_valid(rx_valid), .SPISR(SPISR), .irq(irq)
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, want, $time);
    end
  endtask

  function automatic bit m_err(input bit wr, input logic [4:0] a);
    if (a[1:0] != 2'b00 || a > 5'h14) return 1'b1;
    if (wr && (a == 5'h0C || a == 5'h10)) return 1'b1;
    if (!wr && (a == 5'h08 || a == 5'h14)) return 1'b1;
    if (wr && a == 5'h08 && txq.size() == DEPTH) return 1'b1;
    if (!wr && a == 5'h0C && rxq.size() == 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [4:0] a);
    case (a)
      5'h00:   return {24'b0, m_cr1};
      5'h04:   return {31'b0, m_cr2};
      5'h0C:   return (rxq.size() != 0) ? rxq[0] : 32'h0;
      5'h10:   return {16'b0, SPISR, 1'b0, m_ovr, 3'(rxq.size()), 3'(txq.size())};
      default: return 32'h0;
    endcase
  endfunction

  // Reference model: compare this cycle's outputs, then advance to next cycle's state.
  always @(negedge PCLK) begin
    logic [4:0] a;
    bit e, commit, txpop, rxpop, ovf, irq_n;
    if (!PRESETn) begin
      txq.delete(); rxq.delete();
      m_cr1 = 8'h00; m_cr2 = 1'b0; m_ovr = 1'b0; m_irq = 1'b0;
      chk("rst_pready", PREADY, 0);
      chk("rst_prdata", PRDATA, 0);
      chk("rst_pslverr", PSLVERR, 0);
      chk("rst_spicr_1", SPICR_1, 0);
      chk("rst_spicr_2", SPICR_2, 0);
      chk("rst_mwdata", MWDATA, 0);
      chk("rst_tx_valid", tx_valid, 0);
      chk("rst_irq", irq, 0);
    end else begin
      a = PADDR[4:0];
      e = (phase == 3) && m_err(PWRITE, a);
      chk("pready", PREADY, phase == 3);
      chk("pslverr", PSLVERR, e);
      chk("prdata", PRDATA, (phase == 3 && !e && !PWRITE) ? m_rdata(a) : 32'h0);
      chk("spicr_1", SPICR_1, m_cr1);
      chk("spicr_2", SPICR_2, {7'b0, m_cr2});
      chk("tx_valid", tx_valid, txq.size() != 0);
      chk("mwdata", MWDATA, (txq.size() != 0) ? txq[0] : 32'h0);
      chk("irq", irq, m_irq);

      commit = (phase == 3) && !e;
      irq_n  = m_cr1[5] && (txq.size() == 0 || rxq.size() != 0 || m_ovr);
      txpop  = (txq.size() != 0) && tx_ready;
      rxpop  = commit && !PWRITE && a == 5'h0C;
      ovf    = rx_valid && rxq.size() == DEPTH && !rxpop;
      if (txpop) void'(txq.pop_front());
      if (commit && PWRITE && a == 5'h08) txq.push_back(PWDATA);
      if (rxpop) void'(rxq.pop_front());
      if (rx_valid && !ovf) rxq.push_back(MRDATA);
      if (ovf) m_ovr = 1'b1;
      else if (commit && PWRITE && a == 5'h14 && PWDATA[0]) m_ovr = 1'b0;
      if (commit && PWRITE && a == 5'h00) begin
        if (m_cr1[6] && !PWDATA[6]) begin
          txq.delete(); rxq.delete();
        end
        m_cr1 = PWDATA[7:0];
      end
      if (commit && PWRITE && a == 5'h04) m_cr2 = PWDATA[0];
      m_irq = irq_n;
    end
  end

  initial begin
    forever begin
      @(posedge PCLK); #1;
      if (rand_side) begin
        tx_ready = ($urandom_range(0, 2) == 0);
        rx_valid = ($urandom_range(0, 2) == 0);
        MRDATA   = $urandom();
        SPISR    = 8'($urandom());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge PCLK); #1; end
  endtask

  task automatic apb(input bit wr, input logic [4:0] a, input logic [31:0] wd,
                     input bit rxp, input logic [31:0] rxd,
                     output logic [31:0] rd, output bit err);
    PADDR = {27'($urandom()), a};
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PWDATA = wd; phase = 1;
    @(posedge PCLK); #1;
    PENABLE = 1'b1; phase = 2;
    @(posedge PCLK); #1;
    phase = 3;
    if (rxp) begin rx_valid = 1'b1; MRDATA = rxd; end
    @(negedge PCLK);
    rd  = PRDATA;
    err = PSLVERR;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; phase = 0;
    if (rxp) rx_valid = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    logic [31:0] r;
    bit e;
    apb(1'b1, a, d, 1'b0, 32'h0, r, e);
  endtask

  initial begin
    logic [31:0] rd, wd;
    logic [31:0] w [4];
    logic [4:0]  a;
    bit er, wrb;
    int sel;

    PRESETn = 1'b0; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0;
    tx_ready = 0; rx_valid = 0; MRDATA = 0; SPISR = 8'hA5;
    idle(3);
    PRESETn = 1'b1;
    idle(2);

    // CR1 write/readback
    wr(5'h00, 32'h52);
    apb(1'b0, 5'h00, 32'h0, 1'b0, 32'h0, rd, er);
    chk("cr1_read", rd, 32'h52);
    chk("cr1_read_err", er, 0);
    chk("cr1_out", SPICR_1, 8'h52);

    // TX fill to full, then reject
    w[0] = 32'h1111_0001; w[1] = 32'h2222_0002; w[2] = 32'h3333_0003; w[3] = 32'h4444_0004;
    for (int i = 0; i < 4; i++) wr(5'h08, w[i]);
    apb(1'b0, 5'h10, 32'h0, 1'b0, 32'h0, rd, er);
    chk("tx_count_full", rd[2:0], 4);
    chk("tx_valid_full", tx_valid, 1);
    chk("mwdata_first", MWDATA, w[0]);
    apb(1'b1, 5'h08, 32'hDEAD_BEEF, 1'b0, 32'h0, rd, er);
    chk("tx_overfill_err", er, 1);
    apb(1'b0, 5'h10, 32'h0, 1'b0, 32'h0, rd, er);
    chk("tx_count_kept", rd[2:0], 4);
    chk("mwdata_kept", MWDATA, w[0]);

    // TX drain
    @(posedge PCLK); #1;
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge PCLK);
      chk("tx_drain_word", MWDATA, w[i]);
      @(posedge PCLK); #1;
    end
    tx_ready = 1'b0;
    @(negedge PCLK);
    chk("tx_drained", tx_valid, 0);
    @(posedge PCLK); #1;

    // RX overflow
    for (int k = 1; k <= 5; k++) begin
      rx_valid = 1'b1; MRDATA = 32'(k);
      @(posedge PCLK); #1;
      rx_valid = 1'b0;
      @(posedge PCLK); #1;
    end
    apb(1'b0, 5'h10, 32'h0, 1'b0, 32'h0, rd, er);
    chk("rx_count_ovf", rd[5:3], 4);
    chk("ovr_set", rd[6], 1);
    for (int k = 1; k <= 4; k++) begin
      apb(1'b0, 5'h0C, 32'h0, 1'b0, 32'h0, rd, er);
      chk("rx_read", rd, 32'(k));
    end
    apb(1'b0, 5'h0C, 32'h0, 1'b0, 32'h0, rd, er);
    chk("rx_empty_err", er, 1);
    chk("rx_empty_data", rd, 0);
    wr(5'h14, 32'h1);
    apb(1'b0, 5'h10, 32'h0, 1'b0, 32'h0, rd, er);
    chk("ovr_cleared", rd[6], 0);

    // RX full with simultaneous pop
    for (int k = 1; k <= 4; k++) begin
      rx_valid = 1'b1; MRDATA = 32'(k);
      @(posedge PCLK); #1;
      rx_valid = 1'b0;
      @(posedge PCLK); #1;
    end
    apb(1'b0, 5'h0C, 32'h0, 1'b1, 32'h5, rd, er);
    chk("rx_pop_push_data", rd, 1);
    apb(1'b0, 5'h10, 32'h0, 1'b0, 32'h0, rd, er);
    chk("rx_pop_push_cnt", rd[5:3], 4);
    chk("rx_pop_push_ovr", rd[6], 0);
    apb(1'b0, 5'h0C, 32'h0, 1'b0, 32'h0, rd, er);
    chk("rx_next", rd, 2);

    // irq timing and SPE flush
    wr(5'h00, 32'h60);
    @(negedge PCLK);
    chk("irq_not_yet", irq, 0);
    @(posedge PCLK); #1;
    @(negedge PCLK);
    chk("irq_set", irq, 1);
    @(posedge PCLK); #1;
    wr(5'h08, 32'hAAAA_0001);
    wr(5'h08, 32'hAAAA_0002);
    wr(5'h00, 32'h20);
    apb(1'b0, 5'h10, 32'h0, 1'b0, 32'h0, rd, er);
    chk("flush_tx_count", rd[2:0], 0);
    chk("flush_rx_count", rd[5:3], 0);
    chk("flush_tx_valid", tx_valid, 0);

    // Reset mid-ACCESS
    wr(5'h00, 32'h72);
    wr(5'h04, 32'h1);
    wr(5'h08, 32'hCAFE_F00D);
    rx_valid = 1'b1; MRDATA = 32'h77;
    @(posedge PCLK); #1;
    rx_valid = 1'b0;
    idle(2);
    PADDR = 32'h0; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0; phase = 1;
    @(posedge PCLK); #1;
    PENABLE = 1'b1; phase = 2;
    @(posedge PCLK); #1;
    phase = 3;
    #1;
    chk("pre_rst_pready", PREADY, 1);
    chk("pre_rst_prdata", PRDATA, 32'h72);
    chk("pre_rst_irq", irq, 1);
    #1;
    PRESETn = 1'b0; phase = 0;
    #1;
    chk("async_pready", PREADY, 0);
    chk("async_prdata", PRDATA, 0);
    chk("async_spicr_1", SPICR_1, 0);
    chk("async_spicr_2", SPICR_2, 0);
    chk("async_mwdata", MWDATA, 0);
    chk("async_tx_valid", tx_valid, 0);
    chk("async_irq", irq, 0);
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    idle(3);
    PSEL = 1'b0; PENABLE = 1'b0;
    idle(1);
    apb(1'b0, 5'h00, 32'h0, 1'b0, 32'h0, rd, er);
    chk("cr1_after_reset", rd, 0);

    // Randomized traffic
    rand_side = 1'b1;
    for (int n = 0; n < 500; n++) begin
      sel = $urandom_range(0, 9);
      wrb = 1'($urandom_range(0, 1));
      wd  = $urandom();
      case (sel)
        0: a = 5'h00;
        1: a = 5'h04;
        2, 3: begin a = 5'h08; wrb = ($urandom_range(0, 4) != 0); end
        4, 5: begin a = 5'h0C; wrb = ($urandom_range(0, 4) == 0); end
        6: a = 5'h10;
        7: a = 5'h14;
        8: a = {3'($urandom_range(0, 7)), 2'($urandom_range(1, 3))};
        default: a = ($urandom_range(0, 1) != 0) ? 5'h18 : 5'h1C;
      endcase
      if (a == 5'h00) wd[6] = ($urandom_range(0, 3) != 0);
      apb(wrb, a, wd, 1'b0, 32'h0, rd, er);
      idle($urandom_range(0, 2));
    end
    rand_side = 1'b0;
    tx_ready = 1'b0; rx_valid = 1'b0;
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_apb_regif.md
SPI_APB_REGIF -- requirements
Module: spi_apb_regif

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- ADDR_W, 32, APB address width.
- DATA_W, 32, APB and SPI data word width.
- FIFO_DEPTH, 4, depth of the TX FIFO and of the RX FIFO, in words.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning. Clock and reset are listed first.
- PCLK, in, 1, the single clock; all state updates on its rising edge.
- PRESETn, in, 1, reset; asynchronous, active-low.
- PSEL, PENABLE, PWRITE, in, 1 each, APB3 control.
- PADDR, in, ADDR_W, APB address; only PADDR[4:0] is decoded.
- PWDATA, in, DATA_W, APB write data.
- PRDATA, out, DATA_W, APB read data.
- PREADY, out, 1, APB ready.
- PSLVERR, out, 1, APB error.
- SPICR_1, out, 8, control register 1 to the SPI core: 6 SPE, 5 SPTIE, 4 MSTR, 3 CPOL, 2 CPHASE, 1 SSOE, 0 LSBFE.
- SPICR_2, out, 8, control register 2 to the SPI core; bit 0 SPC0, bits 7:1 always 0.
- MWDATA, out, DATA_W, TX FIFO head word.
- tx_valid, out, 1, TX FIFO not empty.
- tx_ready, in, 1, SPI core accepts the MWDATA word.
- MRDATA, in, DATA_W, received word from the SPI core.
- rx_valid, in, 1, one-cycle strobe: MRDATA is valid.
- SPISR, in, 8, SPI core status: 7 SPIF, 5 SPTEF, 4 MODF.
- irq, out, 1, registered interrupt.

Function
REQ-003 The APB FSM SHALL have three states: IDLE, SETUP, ACCESS.
- IDLE to SETUP on PSEL=1 and PENABLE=0.
- SETUP to ACCESS unconditionally.
- ACCESS to IDLE when PREADY=1.

REQ-004 Every transfer SHALL take exactly one wait state: PREADY=0 on the first ACCESS cycle and 1 on the second. PREADY SHALL be 0 in all other states.

REQ-005 PRDATA and PSLVERR SHALL be valid only while PREADY=1, and 0 otherwise.

REQ-006 Register side effects SHALL occur only on the PREADY=1 cycle, and only if PSLVERR=0.

REQ-007 The register map SHALL be:
- 0x00 CR1: read/write; drives SPICR_1.
- 0x04 CR2: read/write bit 0 only; other bits read 0.
- 0x08 TXDATA: write-only; write pushes PWDATA into the TX FIFO.
- 0x0C RXDATA: read-only; read returns the RX FIFO head and pops it.
- 0x10 STAT: read-only, bits as follows:
  - [15:8] = SPISR.
  - [6] = ovr.
  - [5:3] = rx_count.
  - [2:0] = tx_count.
  - all other bits 0.
- 0x14 CLR: write-only; writing 1 to bit 0 clears ovr.

REQ-008 PSLVERR=1 SHALL be returned, with no state change, for any of:
- PADDR[1:0] not 0.
- Offset above 0x14.
- Write to STAT or RXDATA.
- Read of TXDATA or CLR.
- TXDATA write while the TX FIFO is full.
- RXDATA read while the RX FIFO is empty; PRDATA=0 in this case.

REQ-009 Each FIFO SHALL use:
- log2(FIFO_DEPTH)-bit read and write pointers that wrap from FIFO_DEPTH-1 to 0.
- A count from 0 to FIFO_DEPTH.
- full when count=FIFO_DEPTH; empty when count=0.

REQ-010 TX handshake:
- tx_valid = (tx_count != 0).
- MWDATA = head word when not empty, else 0.
- A pop occurs on a cycle with tx_valid=1 and tx_ready=1.
- tx_ready while empty SHALL be ignored.

REQ-011 A TX push and a TX pop in the same cycle SHALL both take effect, with count unchanged. A push attempted while full is rejected per REQ-008, even if a pop occurs in the same cycle.

REQ-012 RX push occurs on rx_valid=1. If the RX FIFO is full with no simultaneous APB pop, the word SHALL be dropped and ovr set to 1. A full FIFO with a simultaneous APB pop SHALL accept the push, with count unchanged and ovr unchanged.

REQ-013 ovr SHALL be sticky until cleared via CLR. If a CLR write and a new overflow occur in the same cycle, ovr SHALL remain 1.

REQ-014 irq SHALL be registered as: SPICR_1[5] AND (tx_count=0 OR rx_count!=0 OR ovr).

REQ-015 Clearing SPICR_1[6] (SPE) SHALL flush both FIFOs (counts and pointers to 0) on the same update cycle. ovr SHALL be unaffected.

Reset
REQ-016 While PRESETn=0, asynchronously, the following SHALL hold:
- FSM in IDLE.
- PRDATA=0, PREADY=0, PSLVERR=0.
- SPICR_1=0x00, SPICR_2=0x00.
- MWDATA=0, tx_valid=0, irq=0.
- FIFOs empty, ovr=0.

REQ-017 Reset asserted mid-transfer SHALL abort the transfer. After release, the FSM SHALL wait in IDLE for a new SETUP phase.

Verification
REQ-018 Write CR1=0x52, then read CR1 -> PRDATA=0x00000052, PSLVERR=0, SPICR_1=0x52; each access has exactly one PREADY=0 ACCESS cycle.

REQ-019 Hold tx_ready=0 and write TXDATA four times, then a fifth time:
- After the four writes: tx_count=4, tx_valid=1, MWDATA equals the first word.
- Fifth write: PSLVERR=1, and the FIFO is unchanged.

REQ-020 With TX full, hold tx_ready=1 for 4 cycles -> MWDATA steps through words 1 to 4, and then tx_valid=0.

REQ-021 RX overflow and simultaneous pop:
- Pulse rx_valid 5 times with MRDATA=1..5 -> rx_count=4, STAT[6]=1.
- RXDATA reads return 1, 2, 3, 4, then PSLVERR=1.
- Repeat with an APB pop on the 5th pulse -> no overflow.

REQ-022 Set CR1=0x60 with the TX FIFO empty -> irq=1 one cycle later. Then write CR1=0x20 with 2 TX words queued -> tx_count=0 and tx_valid=0.

REQ-023 Assert PRESETn=0 during an ACCESS phase -> all outputs take their reset values immediately, with no PCLK edge required.
